// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: accepts a packet over valid/ready and sends it
// byte by byte (LSB byte first) as 11-bit frames: start, 8 data, even parity, stop.
module uart_tx_ctrl #(
    parameter int PACKET_SIZE  = 32,
    parameter int CLKS_PER_BIT = 16,
    localparam int NUM_BYTES   = PACKET_SIZE / 8,
    localparam int BIW         = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PACKET_SIZE-1:0] packet,
    input  logic                   packet_valid,
    output logic                   packet_ready,
    input  logic                   abort,
    output logic                   tx,
    output logic                   busy,
    output logic [BIW-1:0]         byte_index,
    output logic                   byte_done,
    output logic                   packet_done,
    output logic                   state_dbg
);

    // Handshake: a packet transfers on a rising edge where packet_valid and
    // packet_ready are both high; packet_ready is only ever high in IDLE.

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BIW-1:0] BYTE_LAST = BIW'(NUM_BYTES - 1);

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t                 state, state_nx;
    logic [PACKET_SIZE-1:0] shadow, shadow_nx;
    logic [CW-1:0]          bit_cnt, bit_cnt_nx;
    logic [3:0]             frame_bit, frame_bit_nx;
    logic [BIW-1:0]         byte_index_nx;
    logic                   tx_nx, ready_nx, busy_nx, byte_done_nx, packet_done_nx;
    logic                   accept, bit_wrap, frame_last, byte_last;
    logic [10:0]            frame;

    assign accept     = packet_valid && packet_ready;
    assign bit_wrap   = (bit_cnt == BIT_LAST);
    assign frame_last = (frame_bit == 4'd10);
    assign byte_last  = (byte_index == BYTE_LAST);
    // The byte on the line always sits in the low bits; shadow shifts per frame.
    assign frame      = {1'b1, ^shadow[7:0], shadow[7:0], 1'b0};
    assign state_dbg  = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            shadow       <= '0;
            bit_cnt      <= '0;
            frame_bit    <= '0;
            byte_index   <= '0;
            tx           <= 1'b1;
            packet_ready <= 1'b0;
            busy         <= 1'b0;
            byte_done    <= 1'b0;
            packet_done  <= 1'b0;
        end else begin
            state        <= state_nx;
            shadow       <= shadow_nx;
            bit_cnt      <= bit_cnt_nx;
            frame_bit    <= frame_bit_nx;
            byte_index   <= byte_index_nx;
            tx           <= tx_nx;
            packet_ready <= ready_nx;
            busy         <= busy_nx;
            byte_done    <= byte_done_nx;
            packet_done  <= packet_done_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = SEND;
            SEND: begin
                if (abort)                                state_nx = IDLE;
                else if (bit_wrap && frame_last && byte_last) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        shadow_nx      = shadow;
        bit_cnt_nx     = bit_cnt;
        frame_bit_nx   = frame_bit;
        byte_index_nx  = byte_index;
        tx_nx          = tx;
        ready_nx       = packet_ready;
        busy_nx        = busy;
        byte_done_nx   = 1'b0;
        packet_done_nx = 1'b0;
        case (state)
            IDLE: begin
                tx_nx         = 1'b1;
                ready_nx      = 1'b1;
                busy_nx       = 1'b0;
                byte_index_nx = '0;
                bit_cnt_nx    = '0;
                frame_bit_nx  = '0;
                if (accept) begin
                    shadow_nx = packet;
                    tx_nx     = 1'b0;
                    ready_nx  = 1'b0;
                    busy_nx   = 1'b1;
                end
            end
            SEND: begin
                if (abort) begin
                    // Abort beats any completion landing in the same cycle.
                    tx_nx         = 1'b1;
                    ready_nx      = 1'b1;
                    busy_nx       = 1'b0;
                    byte_index_nx = '0;
                    bit_cnt_nx    = '0;
                    frame_bit_nx  = '0;
                end else if (!bit_wrap) begin
                    bit_cnt_nx = bit_cnt + 1'b1;
                end else begin
                    bit_cnt_nx = '0;
                    if (!frame_last) begin
                        frame_bit_nx = frame_bit + 4'd1;
                        tx_nx        = frame[frame_bit + 4'd1];
                    end else if (!byte_last) begin
                        byte_index_nx = byte_index + 1'b1;
                        frame_bit_nx  = '0;
                        shadow_nx     = shadow >> 8;
                        tx_nx         = 1'b0;
                        byte_done_nx  = 1'b1;
                    end else begin
                        byte_index_nx  = '0;
                        frame_bit_nx   = '0;
                        tx_nx          = 1'b1;
                        ready_nx       = 1'b1;
                        busy_nx        = 1'b0;
                        byte_done_nx   = 1'b1;
                        packet_done_nx = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl with 16-bit packets and 4 clocks per bit;
// every SEND cycle of each packet is compared against a small frame model.
module tb_uart_tx_ctrl;

  localparam int PS  = 16;
  localparam int CPB = 4;
  localparam int FRAME_CYC = 11 * CPB;
  localparam int PKT_CYC   = 2 * FRAME_CYC;

  logic          clk = 1'b0;
  logic          rst;
  logic [PS-1:0] packet;
  logic          packet_valid;
  logic          packet_ready;
  logic          abort;
  logic          tx;
  logic          busy;
  logic [0:0]    byte_index;
  logic          byte_done;
  logic          packet_done;
  logic          state_dbg;

  int n_checks = 0;
  int n_pass   = 0;

  uart_tx_ctrl #(.PACKET_SIZE(PS), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .packet(packet), .packet_valid(packet_valid),
    .packet_ready(packet_ready), .abort(abort), .tx(tx), .busy(busy),
    .byte_index(byte_index), .byte_done(byte_done), .packet_done(packet_done),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // expected line level in SEND cycle c of a 16-bit packet
  function automatic logic exp_tx(input logic [PS-1:0] pkt, input int c);
    logic [7:0] b;
    int f;
    b = (c < FRAME_CYC) ? pkt[7:0] : pkt[15:8];
    f = (c % FRAME_CYC) / CPB;
    if (f == 0)       return 1'b0;
    else if (f <= 8)  return b[f-1];
    else if (f == 9)  return ^b;
    else              return 1'b1;
  endfunction

  // driver: called at a negedge in IDLE with packet_ready high; returns at
  // the negedge of the first SEND cycle
  task automatic start(input logic [PS-1:0] pkt, input bit hold, input logic [PS-1:0] next_pkt);
    packet       = pkt;
    packet_valid = 1'b1;
    @(negedge clk);
    packet_valid = hold;
    if (hold) packet = next_pkt;
  endtask

  // entered at the negedge of SEND cycle 0; returns at the negedge of the
  // first IDLE cycle (after completion or abort)
  task automatic watch(input logic [PS-1:0] pkt, input int abort_at, input bit scramble);
    for (int c = 0; c < PKT_CYC; c++) begin
      if (c > 0) @(negedge clk);
      check($sformatf("tx[%0h c%0d]", pkt, c), tx, exp_tx(pkt, c));
      check($sformatf("byte_done[c%0d]", c), byte_done, (c == FRAME_CYC));
      check($sformatf("packet_done[c%0d]", c), packet_done, 0);
      check($sformatf("busy[c%0d]", c), busy, 1);
      check($sformatf("ready[c%0d]", c), packet_ready, 0);
      check($sformatf("byte_index[c%0d]", c), byte_index, c / FRAME_CYC);
      if (scramble && c == 2) packet = ~pkt;
      if (c == abort_at) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_tx", tx, 1);
        check("abort_ready", packet_ready, 1);
        check("abort_busy", busy, 0);
        check("abort_index", byte_index, 0);
        check("abort_byte_done", byte_done, 0);
        check("abort_packet_done", packet_done, 0);
        check("abort_state", state_dbg, 0);
        return;
      end
    end
    @(negedge clk);
    check("end_tx", tx, 1);
    check("end_byte_done", byte_done, 1);
    check("end_packet_done", packet_done, 1);
    check("end_ready", packet_ready, 1);
    check("end_busy", busy, 0);
    check("end_index", byte_index, 0);
  endtask

  initial begin
    rst          = 1'b1;
    packet       = 16'h1111;
    packet_valid = 1'b1;
    abort        = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_tx", tx, 1);
      check("rst_ready", packet_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_pulses", {byte_done, packet_done}, 0);
      check("rst_state", state_dbg, 0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", packet_ready, 1);
    check("post_rst_busy", busy, 0);
    check("post_rst_tx", tx, 1);

    // single packet, then parity patterns (packet input scrambled after accept)
    start(16'h0701, 1'b0, '0);
    watch(16'h0701, -1, 1'b1);
    start(16'hA53C, 1'b0, '0);
    watch(16'hA53C, -1, 1'b1);
    start(16'hFF80, 1'b0, '0);
    watch(16'hFF80, -1, 1'b1);

    // abort in byte 1, frame bit 5, then restart at once
    start(16'h1234, 1'b0, '0);
    watch(16'h1234, FRAME_CYC + 5 * CPB + 1, 1'b0);
    start(16'hBEEF, 1'b0, '0);
    watch(16'hBEEF, -1, 1'b1);

    // abort together with packet_valid in IDLE: packet still accepted
    abort = 1'b1;
    start(16'h6C93, 1'b0, '0);
    abort = 1'b0;
    watch(16'h6C93, -1, 1'b0);

    // back-to-back with valid held: second start bit 2 cycles after last stop cycle
    start(16'h5A0F, 1'b1, 16'h00C3);
    watch(16'h5A0F, -1, 1'b0);
    @(negedge clk);
    packet_valid = 1'b0;
    watch(16'h00C3, -1, 1'b0);

    @(negedge clk);
    check("idle_tx", tx, 1);
    check("idle_pulses", {byte_done, packet_done}, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Transmit controller for the UART path. It accepts a whole PACKET_SIZE-bit packet through a valid/ready handshake and slices it into bytes, least-significant byte first. Each byte goes out as an 11-bit UART frame on a serial line, with every bit held for CLKS_PER_BIT clocks. It sits between the packet producer and the pin, and owns all byte sequencing, parity generation and bit timing.

Parameters:
PACKET_SIZE, 32, packet width in bits; must be a multiple of 8 and at least 8. NUM_BYTES = PACKET_SIZE/8.
CLKS_PER_BIT, 16, clocks per serial bit; must be at least 2.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous reset, active-high.
packet  input  PACKET_SIZE  packet to send; sampled only on the accept cycle.
packet_valid  input  1  producer has a packet.
packet_ready  output  1  controller can accept; high only in IDLE.
abort  input  1  cancel the packet in flight.
tx  output  1  serial line; idles high.
busy  output  1  high while a packet is in flight.
byte_index  output  max(1,clog2(NUM_BYTES))  index of the byte currently on the line.
byte_done  output  1  one-cycle pulse per completed frame.
packet_done  output  1  one-cycle pulse per completed packet.

Behaviour:
- All outputs are registered. One clock domain. Reset is synchronous and active-high.
- While rst is high: tx=1, packet_ready=0, busy=0, byte_index=0, byte_done=0, packet_done=0, state=IDLE, all counters 0.
- First cycle after rst falls: packet_ready=1.
- States:
  - IDLE: tx=1, packet_ready=1, busy=0.
  - SEND: frame bits shifting out.
- Accept: in IDLE, packet_valid=1 while packet_ready=1.
  - packet is copied into a shadow register; later changes on the packet input have no effect.
  - Next cycle: state=SEND, packet_ready=0, busy=1, tx=0 (start bit), byte_index=0.
- Frame format, 11 bits in this order:
  - start bit = 0;
  - data[0] .. data[7], LSB first;
  - parity = ^data (even parity);
  - stop bit = 1.
- Byte k of a packet is packet[8k+7:8k].
- Bit timing:
  - A bit counter runs 0..CLKS_PER_BIT-1; tx changes only when it wraps.
  - A frame-bit counter runs 0..10.
- After a stop bit completes:
  - If byte_index < NUM_BYTES-1: byte_index increments and the next start bit begins on the very next cycle, with no idle gap. byte_done=1 in that cycle.
  - Otherwise: go to IDLE. In the first IDLE cycle byte_done=1, packet_done=1, tx=1, packet_ready=1 and busy=0.
- Timing:
  - A packet occupies exactly NUM_BYTES*11*CLKS_PER_BIT cycles of SEND.
  - Minimum spacing between back-to-back packets is one IDLE cycle (the accept cycle).
- abort:
  - abort=1 in SEND: next cycle tx=1, state=IDLE, packet_ready=1, busy=0, byte_index=0. No byte_done or packet_done pulse is generated.
  - abort=1 in IDLE is ignored.
  - abort and packet_valid both high in IDLE: the packet is accepted (abort ignored).
- Simultaneous events:
  - rst has priority over everything.
  - abort has priority over a frame or packet completion in the same cycle.
- packet_valid while busy: ignored, since packet_ready=0. The producer holds it until accepted.

Test Plan:
- Reset: hold rst 3 cycles with packet_valid=1 -> tx=1, packet_ready=0, no accept; first cycle after release packet_ready=1.
- Single packet, PACKET_SIZE=16, CLKS_PER_BIT=4, packet=0x0701:
  - tx sequence, each bit held 4 cycles: 0, 1,0,0,0,0,0,0,0, 1(parity), 1, then 0, 1,1,1,0,0,0,0,0, 1(parity), 1.
  - byte_done pulses at cycle 44 after the first start bit and again at cycle 88.
  - packet_done pulses at cycle 88.
  - 88 SEND cycles total.
- Parity check, packet=0xA53C -> both parity bits 0; packet=0xFF80 -> parity bits 1 (byte0) and 0 (byte1).
- Input isolation: change packet 2 cycles after accept -> serial data still matches the value sampled at accept.
- Abort in byte 1, frame bit 5 -> next cycle tx=1 and packet_ready=1, no packet_done. A new packet accepted immediately after transmits correctly from byte 0.
- Back-to-back: packet_valid held high with two packets queued -> second start bit begins exactly 2 cycles after the first packet's last stop-bit cycle (one IDLE/accept cycle, then SEND).
